// File: rtl/costas_phase_estimator_pkg.sv
// Costas loop phase estimator: shared types and widths.
// State encoding and fixed-point formats used across the block.
package costas_pkg;

    localparam int PHASE_W = 32;
    localparam int Q_FRAC  = 30;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_DETECT,
        ST_FILTER,
        ST_UPDATE
    } state_t;

endpackage

// File: rtl/costas_phase_estimator_if.sv
// Costas loop phase estimator: sample in / phase out bundle.
// Master drives samples and carrier, slave returns the estimate.
interface costas_phase_estimator_if;
    import costas_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic signed [DATA_W-1:0]  rx_sample;
    logic signed [PHASE_W-1:0] cos_in;
    logic signed [PHASE_W-1:0] sin_in;
    logic signed [PHASE_W-1:0] phi_est;
    logic                      phi_valid;
    logic signed [PHASE_W-1:0] err_out;

    modport master (
        output in_valid,
        output rx_sample,
        output cos_in,
        output sin_in,
        input  in_ready,
        input  phi_est,
        input  phi_valid,
        input  err_out
    );

    modport slave (
        input  in_valid,
        input  rx_sample,
        input  cos_in,
        input  sin_in,
        output in_ready,
        output phi_est,
        output phi_valid,
        output err_out
    );

endinterface

// File: rtl/costas_phase_estimator_iq_mixer.sv
// Costas loop phase estimator: I/Q down-mixer.
// Q2.30 carrier times sample, rescaled back to sample units.
module iq_mixer
    import costas_pkg::*;
(
    input  logic signed [DATA_W-1:0]  rx_sample,
    input  logic signed [PHASE_W-1:0] cos_in,
    input  logic signed [PHASE_W-1:0] sin_in,
    output logic signed [PHASE_W-1:0] i_prod,
    output logic signed [PHASE_W-1:0] q_prod
);

    localparam int PROD_W = DATA_W + PHASE_W;

    logic signed [PROD_W-1:0] i_full;
    logic signed [PROD_W-1:0] q_full;

    assign i_full = rx_sample * cos_in;
    assign q_full = rx_sample * sin_in;

    // Shifted products span 18 bits, so the 32-bit truncation is exact.
    assign i_prod = PHASE_W'(i_full >>> Q_FRAC);
    assign q_prod = -PHASE_W'(q_full >>> Q_FRAC);

endmodule

// File: rtl/costas_phase_estimator.sv
// Costas loop phase estimator: integrate-and-dump, detector, PI filter.
// One phase update per DUMP_LEN accepted samples.
module costas_phase_estimator
    import costas_pkg::*;
#(
    parameter int DUMP_LEN  = 16,
    parameter int KP_SHIFT  = 4,
    parameter int KI_SHIFT  = 8,
    parameter int INTEG_LIM = 32767
) (
    input  logic                     clk,
    input  logic                     reset,
    costas_phase_estimator_if.slave  bus
);

    localparam int CW = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
    localparam int SW = PHASE_W + 2;
    localparam logic [CW-1:0] LAST = CW'(DUMP_LEN - 1);
    localparam logic signed [SW-1:0] LIM_HI = SW'(INTEG_LIM);
    localparam logic signed [SW-1:0] LIM_LO = -SW'(INTEG_LIM);

    state_t                    state;
    logic [CW-1:0]             count;
    logic signed [PHASE_W-1:0] i_acc;
    logic signed [PHASE_W-1:0] q_acc;
    logic signed [PHASE_W-1:0] integ;
    logic signed [PHASE_W-1:0] phi_est;
    logic signed [PHASE_W-1:0] err_out;
    logic                      phi_valid;

    logic signed [PHASE_W-1:0] i_prod;
    logic signed [PHASE_W-1:0] q_prod;
    logic signed [PHASE_W-1:0] err_c;
    logic signed [SW-1:0]      integ_sum;
    logic signed [PHASE_W-1:0] integ_sat;
    logic                      accept;

    iq_mixer u_mixer (
        .rx_sample (bus.rx_sample),
        .cos_in    (bus.cos_in),
        .sin_in    (bus.sin_in),
        .i_prod    (i_prod),
        .q_prod    (q_prod)
    );

    assign bus.in_ready  = (state == ST_ACCUM);
    assign bus.phi_est   = phi_est;
    assign bus.phi_valid = phi_valid;
    assign bus.err_out   = err_out;

    assign accept = bus.in_valid && (state == ST_ACCUM);

    // Detector and saturating integrator input, evaluated from registers.
    always_comb begin
        err_c     = i_acc[PHASE_W-1] ? -q_acc : q_acc;
        integ_sum = SW'(integ) + SW'(err_out >>> KI_SHIFT);
        integ_sat = integ_sum[PHASE_W-1:0];
        if (integ_sum > LIM_HI) begin
            integ_sat = LIM_HI[PHASE_W-1:0];
        end else if (integ_sum < LIM_LO) begin
            integ_sat = LIM_LO[PHASE_W-1:0];
        end
    end

    // Frame FSM: accumulate, detect, filter, then update the phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_ACCUM;
            count     <= '0;
            i_acc     <= '0;
            q_acc     <= '0;
            integ     <= '0;
            phi_est   <= '0;
            err_out   <= '0;
            phi_valid <= 1'b0;
        end else begin
            phi_valid <= 1'b0;
            unique case (state)
                ST_ACCUM: begin
                    if (accept) begin
                        i_acc <= i_acc + i_prod;
                        q_acc <= q_acc + q_prod;
                        if (count == LAST) begin
                            count <= '0;
                            state <= ST_DETECT;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                ST_DETECT: begin
                    err_out <= err_c;
                    state   <= ST_FILTER;
                end
                ST_FILTER: begin
                    integ <= integ_sat;
                    state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    phi_est   <= phi_est + integ + (err_out >>> KP_SHIFT);
                    phi_valid <= 1'b1;
                    i_acc     <= '0;
                    q_acc     <= '0;
                    state     <= ST_ACCUM;
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_costas_phase_estimator.sv
// Directed bench for the Costas loop phase estimator.
// Hand-computed frame results checked with immediate assertions.
module tb_costas_phase_estimator;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    costas_phase_estimator_if bus();

    costas_phase_estimator #(
        .DUMP_LEN  (16),
        .KP_SHIFT  (4),
        .KI_SHIFT  (8),
        .INTEG_LIM (32767)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic signed [31:0] P30 = 32'sh4000_0000;
    localparam logic signed [31:0] N30 = 32'shC000_0000;
    localparam logic signed [31:0] P29 = 32'sh2000_0000;
    localparam logic signed [31:0] N29 = 32'shE000_0000;

    task automatic check(input string tag,
                         input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic feed(input int n,
                        input logic signed [15:0] rx,
                        input logic signed [31:0] c,
                        input logic signed [31:0] s);
        bus.rx_sample = rx;
        bus.cos_in    = c;
        bus.sin_in    = s;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    // Called #1 after the edge that accepted the last sample of a frame.
    task automatic wait_update(input string tag,
                               input logic signed [63:0] e_err,
                               input logic signed [63:0] e_phi);
        @(posedge clk);
        #1;
        check({tag, "_pv_c1"}, bus.phi_valid, 0);
        @(posedge clk);
        #1;
        check({tag, "_pv_c2"}, bus.phi_valid, 0);
        @(posedge clk);
        #1;
        check({tag, "_pv_c3"}, bus.phi_valid, 1);
        check({tag, "_err"}, bus.err_out, e_err);
        check({tag, "_phi"}, bus.phi_est, e_phi);
    endtask

    initial begin
        int acc;
        logic ok;
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.in_valid  = 1'b0;
        bus.rx_sample = '0;
        bus.cos_in    = '0;
        bus.sin_in    = '0;

        do_reset(2);
        check("rst_phi", bus.phi_est, 0);
        check("rst_err", bus.err_out, 0);
        check("rst_pv", bus.phi_valid, 0);
        check("rst_rdy", bus.in_ready, 1);

        feed(16, 16'sd1000, P30, 32'sd0);
        check("f0_busy", bus.in_ready, 0);
        wait_update("f0", 0, 0);
        @(posedge clk);
        #1;
        check("f0_pv_drop", bus.phi_valid, 0);
        check("f0_rdy", bus.in_ready, 1);

        do_reset(1);
        feed(16, 16'sd1000, P29, N29);
        wait_update("f1", 8000, 531);

        do_reset(1);
        feed(16, 16'sd1000, N29, N29);
        wait_update("f2", -8000, -532);

        do_reset(1);
        bus.rx_sample = 16'sd1000;
        bus.cos_in    = P29;
        bus.sin_in    = N29;
        acc = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && acc < 16; i++) begin
            ok = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) acc++;
            bus.in_valid = ~bus.in_valid;
        end
        check("tg_acc", acc, 16);
        bus.in_valid = 1'b1;
        wait_update("tg", 8000, 531);
        bus.in_valid = 1'b0;
        feed(15, 16'sd1000, P29, N29);
        repeat (3) @(posedge clk);
        #1;
        check("tg_nopv", bus.phi_valid, 0);
        check("tg_rdy", bus.in_ready, 1);
        feed(1, 16'sd1000, P29, N29);
        wait_update("tg2", 8000, 1093);

        do_reset(1);
        for (int f = 1; f <= 16; f++) begin
            feed(16, -16'sd32768, N30, P30);
            wait_update("sat", 524288, bus.phi_est + 2048 * f + 32768 -
                        ((f == 16) ? 1 : 0));
        end
        check("sat_phi16", bus.phi_est, 802815);

        do_reset(1);
        feed(8, 16'sd1000, P30, 32'sd0);
        do_reset(1);
        feed(15, 16'sd1000, P30, 32'sd0);
        repeat (4) @(posedge clk);
        #1;
        check("mr_nopv", bus.phi_valid, 0);
        check("mr_rdy", bus.in_ready, 1);
        feed(1, 16'sd1000, P30, 32'sd0);
        wait_update("mr", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/costas_phase_estimator.md
COSTAS_PHASE_ESTIMATOR -- requirements
Module: costas_phase_estimator

Interface
REQ-001 Parameter DUMP_LEN, default 16: samples per integrate-and-dump frame (power of two, 2..256).
REQ-002 Parameter KP_SHIFT, default 4: proportional gain as an arithmetic right-shift of the phase error.
REQ-003 Parameter KI_SHIFT, default 8: integral gain as an arithmetic right-shift of the phase error.
REQ-004 Parameter INTEG_LIM, default 32767: symmetric saturation limit of the loop integrator.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  rx_sample/cos_in/sin_in valid this cycle.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 rx_sample  input  signed 16  received passband sample.
REQ-010 cos_in  input  signed 32  local carrier cosine, Q2.30.
REQ-011 sin_in  input  signed 32  local carrier sine, Q2.30.
REQ-012 phi_est  output  signed 32  phase estimate fed back to the local carrier NCO.
REQ-013 phi_valid  output  1  one-cycle pulse when phi_est has just been updated.
REQ-014 err_out  output  signed 32  phase error of the most recent frame.

Function
REQ-015 Accept a sample when in_valid && in_ready; cos_in and sin_in are sampled in the same cycle as rx_sample.
REQ-016 Mixer: i_prod = (rx_sample*cos_in) >>> 30; q_prod = -((rx_sample*sin_in) >>> 30); products at 48 bits, results sign-extended to 32 bits.
REQ-017 FSM states ACCUM, DETECT, FILTER, UPDATE; in_ready = 1 only in ACCUM.
REQ-018 ACCUM: each accepted sample adds i_prod to i_acc and q_prod to q_acc (32-bit, two's-complement) and increments sample count; in_valid low leaves all state unchanged.
REQ-019 ACCUM -> DETECT on acceptance of sample number DUMP_LEN; count then wraps to 0.
REQ-020 DETECT (1 cycle): err = (i_acc >= 0) ? q_acc : -q_acc; err_out <= err; i_acc == 0 counts as positive.
REQ-021 FILTER (1 cycle): integ <= sat(integ + (err >>> KI_SHIFT)), clamped to [-INTEG_LIM, +INTEG_LIM].
REQ-022 UPDATE (1 cycle): phi_est <= phi_est + integ + (err >>> KP_SHIFT), wrapping modulo 2^32 (no saturation); phi_valid = 1; i_acc, q_acc cleared; next state ACCUM.
REQ-023 Latency: phi_valid is high exactly 3 cycles after the clock edge that accepts the DUMP_LEN-th sample.
REQ-024 in_valid asserted in DETECT, FILTER or UPDATE is ignored; no sample is counted or accumulated.
REQ-025 phi_valid is low in every cycle other than UPDATE; phi_est and err_out hold their values between updates.

Reset
REQ-026 While reset is high at a clock edge: state = ACCUM, count = 0, i_acc = q_acc = integ = 0, phi_est = 0, err_out = 0, phi_valid = 0; in_ready reads 1 in the following cycle.
REQ-027 Reset asserted mid-frame or mid-FSM discards the partial frame and any pending update; reset has priority over all other events.

Structure
REQ-028 Shared package costas_pkg holds the state enum, PHASE_W=32, Q_FRAC=30 and DATA_W=16.
REQ-029 Sub-module iq_mixer implements REQ-016 combinationally; accumulation, FSM and loop filter are in the top-level module.

Verification
REQ-030 Reset check: assert reset for 2 cycles -> phi_est=0, err_out=0, phi_valid=0, in_ready=1.
REQ-031 rx=1000, cos=2^30, sin=0, 16 samples -> err_out=0, phi_est=0, phi_valid pulses exactly 3 cycles after the 16th accepted sample.
REQ-032 rx=1000, cos=2^29, sin=-2^29, 16 samples -> err_out=8000, phi_est=531; next frame with cos=-2^29, sin=-2^29 from reset -> err_out=-8000, phi_est=-532.
REQ-033 Same stimulus as REQ-032, with in_valid toggled 1/0 every cycle and held high during DETECT through UPDATE -> identical result; extra samples are not counted.
REQ-034 rx=-32768, cos=-2^30, sin=2^30, 16 consecutive frames -> err_out=524288 per frame; integ reaches +INTEG_LIM=32767 on frame 16 and does not wrap.
REQ-035 Reset pulsed after 8 samples, then the REQ-031 stimulus -> first phi_valid occurs only after 16 post-reset samples, with phi_est=0.
